// File: rtl/imem_boot_loader.sv
// Byte-serial instruction-memory loader: parses a length/payload/XOR-checksum frame,
// writes assembled 32-bit words into instruction memory, then releases the CPU from reset.
module imem_boot_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_t      state;
  state_t      next_state;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [15:0] word_cnt;
  logic [1:0]  lane;
  logic [23:0] word_buf;
  logic [7:0]  chk;

  logic        accept;
  logic        start_ok;
  logic [15:0] len_full;
  logic        len_too_big;
  logic        last_word;

  assign in_ready    = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                       (state == S_DATA)   || (state == S_CHECK);
  assign cpu_rst     = (state != S_DONE);
  assign done        = (state == S_DONE);
  assign err         = (state == S_ERROR);
  assign accept      = in_valid && in_ready;
  assign start_ok    = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
  assign len_full    = {in_data, len_lo};
  // 17-bit compare so a full 2^ADDR_W-word program is still accepted
  assign len_too_big = ({1'b0, len_full} > (17'd1 << ADDR_W));
  assign last_word   = (word_cnt == (len - 16'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start) next_state = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (accept) next_state = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (accept) begin
          if (len_full == 16'd0) next_state = S_CHECK;
          else if (len_too_big)  next_state = S_ERROR;
          else                   next_state = S_DATA;
        end
      end
      S_DATA: begin
        if (accept && (lane == 2'd3) && last_word) next_state = S_CHECK;
      end
      S_CHECK: begin
        if (accept) next_state = ((chk ^ in_data) == 8'd0) ? S_DONE : S_ERROR;
      end
      S_DONE, S_ERROR: begin
        if (start) next_state = S_LEN_LO;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Datapath: byte assembly, running checksum and the one-cycle write strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_lo     <= 8'd0;
      len        <= 16'd0;
      word_cnt   <= 16'd0;
      lane       <= 2'd0;
      word_buf   <= 24'd0;
      chk        <= 8'd0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
    end else begin
      imem_we <= 1'b0;
      if (start_ok) begin
        word_cnt <= 16'd0;
        lane     <= 2'd0;
        chk      <= 8'd0;
      end
      if (accept) begin
        chk <= chk ^ in_data;
        case (state)
          S_LEN_LO: len_lo <= in_data;
          S_LEN_HI: len    <= len_full;
          S_DATA: begin
            lane <= lane + 2'd1;
            case (lane)
              2'd0: word_buf[7:0]   <= in_data;
              2'd1: word_buf[15:8]  <= in_data;
              2'd2: word_buf[23:16] <= in_data;
              default: begin
                imem_we    <= 1'b1;
                imem_addr  <= BASE + word_cnt[ADDR_W-1:0];
                imem_wdata <= {in_data, word_buf};
                word_cnt   <= word_cnt + 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule
